// File: rtl/nway_wb_cache.sv
// nway_wb_cache: N-way set-associative, write-back, write-allocate cache with age-based LRU replacement
module nway_wb_cache #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 32,
    parameter int NUM_WAYS     = 4,
    parameter int NUM_SETS     = 8,
    parameter int OFFSET_WIDTH = 2,
    parameter int SET_WIDTH    = $clog2(NUM_SETS),
    parameter int TAG_WIDTH    = ADDR_WIDTH - SET_WIDTH - OFFSET_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cpu_req_valid,
    input  logic                  cpu_req_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    output logic                  cpu_ready,
    output logic                  mem_req_valid,
    output logic                  mem_req_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_ready,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [31:0]           hit_count,
    output logic [31:0]           miss_count
);
    localparam int AGE_WIDTH = $clog2(NUM_WAYS);

    typedef enum logic [1:0] {IDLE, WRITEBACK, REFILL, RESPOND} state_t;

    state_t                state, state_n;
    logic [DATA_WIDTH-1:0] data_mem [NUM_SETS][NUM_WAYS];
    logic [TAG_WIDTH-1:0]  tag_mem  [NUM_SETS][NUM_WAYS];
    logic [AGE_WIDTH-1:0]  age      [NUM_SETS][NUM_WAYS];
    logic [NUM_WAYS-1:0]   valid    [NUM_SETS];
    logic [NUM_WAYS-1:0]   dirty    [NUM_SETS];
    logic [AGE_WIDTH-1:0]  victim_q, victim, hit_way, touch_way;
    logic                  hit, has_free, hit_acc, miss_acc, fill;
    logic [SET_WIDTH-1:0]  set;
    logic [TAG_WIDTH-1:0]  tag;
    logic                  unused_offset;

    assign set           = cpu_addr[SET_WIDTH+OFFSET_WIDTH-1:OFFSET_WIDTH];
    assign tag           = cpu_addr[ADDR_WIDTH-1 -: TAG_WIDTH];
    assign unused_offset = ^cpu_addr[OFFSET_WIDTH-1:0];
    assign hit_acc       = state == IDLE && cpu_req_valid && hit;
    assign miss_acc      = state == IDLE && cpu_req_valid && !hit;
    assign fill          = state == REFILL && mem_ready;
    assign touch_way     = fill ? victim_q : hit_way;

    // Tag match and victim choice: lowest free way, otherwise the oldest (age NUM_WAYS-1) way
    always_comb begin
        hit      = 1'b0;
        hit_way  = '0;
        has_free = 1'b0;
        victim   = '0;
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (valid[set][w] && tag_mem[set][w] == tag) begin
                hit     = 1'b1;
                hit_way = AGE_WIDTH'(w);
            end
            if (!valid[set][w]) begin
                has_free = 1'b1;
                victim   = AGE_WIDTH'(w);
            end
        end
        if (!has_free)
            for (int w = 0; w < NUM_WAYS; w++)
                if (age[set][w] == AGE_WIDTH'(NUM_WAYS - 1)) victim = AGE_WIDTH'(w);
    end

    // Next-state and CPU/memory handshake outputs
    always_comb begin
        state_n       = state;
        cpu_ready     = 1'b0;
        cpu_rdata     = data_mem[set][hit_way];
        mem_req_valid = 1'b0;
        mem_req_we    = 1'b0;
        mem_addr      = {cpu_addr[ADDR_WIDTH-1:OFFSET_WIDTH], {OFFSET_WIDTH{1'b0}}};
        mem_wdata     = data_mem[set][victim_q];
        case (state)
            IDLE: if (cpu_req_valid) begin
                cpu_ready = hit;
                if (!hit) state_n = (valid[set][victim] && dirty[set][victim]) ? WRITEBACK : REFILL;
            end
            WRITEBACK: begin
                mem_req_valid = 1'b1;
                mem_req_we    = 1'b1;
                mem_addr      = {tag_mem[set][victim_q], set, {OFFSET_WIDTH{1'b0}}};
                if (mem_ready) state_n = REFILL;
            end
            REFILL: begin
                mem_req_valid = 1'b1;
                if (mem_ready) state_n = RESPOND;
            end
            default: begin
                cpu_ready = 1'b1;
                cpu_rdata = data_mem[set][victim_q];
                state_n   = IDLE;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // Valid/dirty/age bookkeeping, victim capture and saturating counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            victim_q   <= '0;
            hit_count  <= '0;
            miss_count <= '0;
            for (int s = 0; s < NUM_SETS; s++) begin
                valid[s] <= '0;
                dirty[s] <= '0;
                for (int w = 0; w < NUM_WAYS; w++) age[s][w] <= AGE_WIDTH'(w);
            end
        end else begin
            if (hit_acc && hit_count != '1) hit_count <= hit_count + 32'd1;
            if (hit_acc && cpu_req_we) dirty[set][hit_way] <= 1'b1;
            if (miss_acc) victim_q <= victim;
            if (miss_acc && miss_count != '1) miss_count <= miss_count + 32'd1;
            if (fill) begin
                valid[set][victim_q] <= 1'b1;
                dirty[set][victim_q] <= cpu_req_we;
            end
            if (hit_acc || fill)
                for (int w = 0; w < NUM_WAYS; w++)
                    if (AGE_WIDTH'(w) == touch_way) age[set][w] <= '0;
                    else if (age[set][w] < age[set][touch_way]) age[set][w] <= age[set][w] + AGE_WIDTH'(1);
        end
    end

    // Word and tag storage, left unreset since valid bits gate their use
    always_ff @(posedge clk) begin
        if (hit_acc && cpu_req_we) data_mem[set][hit_way] <= cpu_wdata;
        if (fill) begin
            data_mem[set][victim_q] <= cpu_req_we ? cpu_wdata : mem_rdata;
            tag_mem[set][victim_q]  <= tag;
        end
    end
endmodule

// File: doc/nway_wb_cache.md
NWAY_WB_CACHE -- requirements
Module: nway_wb_cache

Interface
REQ-001 Parameters SHALL be: DATA_WIDTH, default 32, word width; ADDR_WIDTH, default 32, byte address width; NUM_WAYS, default 4, associativity (power of 2, 2..8); NUM_SETS, default 8, sets (power of 2); OFFSET_WIDTH, default 2, byte offset; SET_WIDTH = log2(NUM_SETS); TAG_WIDTH = ADDR_WIDTH-SET_WIDTH-OFFSET_WIDTH.
REQ-002 Ports SHALL be: clk  in  1  sole clock, all state on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 cpu_req_valid  in  1  CPU request present; cpu_req_we  in  1  1=write, 0=read.
REQ-005 cpu_addr  in  ADDR_WIDTH  byte address; set = addr[SET_WIDTH+OFFSET_WIDTH-1:OFFSET_WIDTH], tag = upper TAG_WIDTH bits.
REQ-006 cpu_wdata  in  DATA_WIDTH  write data; cpu_rdata  out  DATA_WIDTH  read data; cpu_ready  out  1  request complete this cycle.
REQ-007 mem_req_valid  out  1; mem_req_we  out  1; mem_addr  out  ADDR_WIDTH; mem_wdata  out  DATA_WIDTH; mem_ready  in  1; mem_rdata  in  DATA_WIDTH.
REQ-008 hit_count, miss_count  out  32  saturating performance counters.

Function
REQ-009 Each line SHALL hold one word plus V, D, tag and an age of log2(NUM_WAYS) bits; age 0 = MRU.
REQ-010 FSM states SHALL be IDLE, WRITEBACK, REFILL, RESPOND; only IDLE accepts requests.
REQ-011 Hit (IDLE, valid, any way V=1 with matching tag): cpu_ready=1 combinationally same cycle; read drives cpu_rdata combinationally from hit way; write stores cpu_wdata, sets D=1 at the rising edge; FSM stays IDLE.
REQ-012 CPU SHALL hold request stable until cpu_ready; the block SHALL sample it while not IDLE without re-arbitration.
REQ-013 Miss victim: lowest-index way with V=0; else the way with maximum age; victim latched on leaving IDLE.
REQ-014 Miss with dirty valid victim: IDLE->WRITEBACK; mem_req_valid=1, mem_req_we=1, mem_addr={victim tag, set, zero offset}, mem_wdata=victim data, held until mem_ready=1, then ->REFILL.
REQ-015 Miss with clean or invalid victim: IDLE->REFILL directly.
REQ-016 REFILL: mem_req_valid=1, mem_req_we=0, mem_addr=cpu_addr with offset zeroed; on mem_ready install tag, V=1; read miss stores mem_rdata, D=0; write miss (write-allocate) stores cpu_wdata, D=1; ->RESPOND.
REQ-017 RESPOND: cpu_ready=1 for exactly one cycle, cpu_rdata = installed word; ->IDLE.
REQ-018 mem_req_valid SHALL be 0 in IDLE and RESPOND; mem outputs SHALL stay stable while mem_ready=0.
REQ-019 LRU update on every hit and every install of way w with prior age a: each other way in the set with age < a increments, w set to 0; ages in a set remain a permutation of 0..NUM_WAYS-1.
REQ-020 hit_count increments on each REQ-011 hit; miss_count increments on each IDLE exit; both saturate at 2^32-1.
REQ-021 cpu_req_valid=0 in IDLE SHALL cause no state, LRU or counter change.

Reset
REQ-022 rst=1 SHALL immediately force FSM to IDLE, cpu_ready=0, mem_req_valid=0, mem_req_we=0, all V=0, all D=0, ages in every set = way index, counters=0; data/tag arrays unreset.
REQ-023 rst during WRITEBACK/REFILL SHALL abandon the memory transaction with no write-back retry; first post-reset access misses.

Verification (NUM_WAYS=4, NUM_SETS=8, 32-bit)
REQ-024 Cold read 0x40, mem_ready after 3 cycles with 0xDEADBEEF -> one read mem_req at 0x40, RESPOND cpu_rdata=0xDEADBEEF, miss_count=1; re-read 0x40 -> same-cycle cpu_ready, hit_count=1, no mem_req.
REQ-025 Write 0x40 data 0x12345678 (hit), then read 0x40 -> 0x12345678, zero mem traffic.
REQ-026 Write-miss 0x20 data 0xA5A5A5A5, read 0x00, 0x40, 0x60, read 0x00, read 0x80 -> WRITEBACK at mem_addr 0x20 data 0xA5A5A5A5, then REFILL at 0x80; 0x00, 0x40, 0x60 still hit.
REQ-027 mem_ready held 0 for 10 cycles in REFILL -> mem_addr/mem_req_valid stable, cpu_ready=0 throughout.
REQ-028 rst pulsed mid-REFILL -> mem_req_valid=0 same cycle, counters=0; read of previously cached 0x40 misses afterward.
